instruction_fetch: RTL

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the fetch PC and drives the cache's level-held read handshake. Returned words are buffered, with their PCs, in a small queue that feeds decode. Branch/jump redirects from execute flush the queue and any in-flight fetch without ever changing the cache address mid-transaction.

---
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the level-held icache read
// handshake, and buffers returned words with their PCs in a small queue to decode.
// Redirects flush the queue; an in-flight miss is drained before the PC moves.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_read_request,
  output logic [31:0] icache_addr,
  input  logic        icache_read_response,
  input  logic [31:0] icache_read_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     pending_pc_q;
  logic            req_q;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     q_pc_q   [QUEUE_DEPTH];
  logic [31:0]     q_data_q [QUEUE_DEPTH];

  logic        push, pop;
  logic        has_room;
  logic [31:0] redirect_target;

  assign redirect_target     = redirect_pc & ~32'h1;
  assign icache_read_request = req_q;
  assign icache_addr         = pc_q;
  assign instr_valid         = (count_q != '0);
  assign instr_data          = instr_valid ? q_data_q[rd_ptr_q] : 32'h0;
  assign instr_pc            = instr_valid ? q_pc_q[rd_ptr_q] : 32'h0;

  // Queue control: a redirect voids any pop/push this cycle and empties the queue.
  always_comb begin
    push     = (state_q == StFetch) && icache_read_response && !redirect;
    pop      = instr_valid && instr_ready && !redirect;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
    has_room = (count_d < DepthC);
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are only observed through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]   <= pc_q;
      q_data_q[wr_ptr_q] <= icache_read_data;
    end
  end

  // Fetch FSM: pc and request only change when no transaction is outstanding
  // or at the edge where the outstanding response arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      pending_pc_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect) begin
            pc_q    <= redirect_target;
            state_q <= StFetch;
            req_q   <= 1'b1;
          end else if (has_room) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (icache_read_response) begin
            if (redirect) begin
              pc_q <= redirect_target;
            end else begin
              pc_q <= pc_q + 32'd4;
              if (!has_room) begin
                state_q <= StIdle;
                req_q   <= 1'b0;
              end
            end
          end else if (redirect) begin
            // Miss outstanding: address must hold until the cache answers.
            pending_pc_q <= redirect_target;
            state_q      <= StDrain;
          end
        end
        StDrain: begin
          if (icache_read_response) begin
            // A redirect landing on the drain response is the newest target.
            pc_q    <= redirect ? redirect_target : pending_pc_q;
            state_q <= StFetch;
            req_q   <= 1'b1;
          end else if (redirect) begin
            pending_pc_q <= redirect_target;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
